// File: rtl/mux8_arb_pkg.sv
// Shared types and constants for the round-robin arbiter in front of the 8:1 mux.
package mux8_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Next round-robin position; wraps 7 -> 0 through the natural 3-bit overflow.
  function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] ptr);
    return ptr + 1'b1;
  endfunction

endpackage

// File: rtl/mux8_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, with wrap.
module mux8_rr_pick
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] idx,
  output logic [N_REQ-1:0] onehot
);

  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;
  logic             found;

  always_comb begin
    rot    = '0;
    off    = '0;
    found  = 1'b0;
    onehot = '0;
    // rot[0] is the highest-priority requester, so a lowest-bit scan gives the winner.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      rot[i] = req[SEL_W'(i) + ptr];
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (rot[i] && !found) begin
        found = 1'b1;
        off   = SEL_W'(i);
      end
    end
    valid       = |req;
    idx         = off + ptr;
    onehot[idx] = valid;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner of the 8:1 mux select with a registered data tap.
// Optional grant hold limit: define MUX8_ARB_TIMEOUT_EN.
module mux8_rr_arbiter #(
  parameter int unsigned N_REQ    = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] ip,
  output logic [7:0] gnt,
  output logic [2:0] select,
  output logic       y,
  output logic       busy,
  output logic       timeout
);

  import mux8_arb_pkg::*;

  if (N_REQ != mux8_arb_pkg::N_REQ || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_cfg
    $error("mux8_rr_arbiter: N_REQ must be 8 and MAX_HOLD within 2..255");
  end

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] gnt_q, gnt_d;
  logic       y_q, y_d;
  logic       drop;

  logic       pick_valid;
  logic [2:0] pick_idx;
  logic [7:0] pick_onehot;

  mux8_rr_pick u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

`ifdef MUX8_ARB_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic       to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    y_d     = y_q;
    drop    = 1'b0;
`ifdef MUX8_ARB_TIMEOUT_EN
    hold_d  = hold_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = pick_onehot;
          sel_d   = pick_idx;
`ifdef MUX8_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      GRANT: begin
        // A release on the limit edge wins, so the pulse needs req still high.
        if (!req[sel_q]) begin
          drop = 1'b1;
        end
`ifdef MUX8_ARB_TIMEOUT_EN
        else if (hold_q == 8'(MAX_HOLD - 1)) begin
          drop = 1'b1;
          to_d = 1'b1;
        end
`endif
        if (drop) begin
          state_d = IDLE;
          gnt_d   = '0;
          y_d     = 1'b0;
          ptr_d   = rr_next(sel_q);
        end else begin
          y_d     = ip[sel_q];
`ifdef MUX8_ARB_TIMEOUT_EN
          hold_d  = hold_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      gnt_q   <= '0;
      y_q     <= 1'b0;
`ifdef MUX8_ARB_TIMEOUT_EN
      hold_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      y_q     <= y_d;
`ifdef MUX8_ARB_TIMEOUT_EN
      hold_q  <= hold_d;
      to_q    <= to_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign select = sel_q;
  assign y      = y_q;
  assign busy   = (state_q == GRANT);
`ifdef MUX8_ARB_TIMEOUT_EN
  assign timeout = to_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter: directed table, corner sequences, random vs model.
module tb_mux8_rr_arbiter;

`ifdef MUX8_ARB_TIMEOUT_EN
  localparam int unsigned TB_HOLD = 4;
  localparam bit          TB_TO   = 1'b1;
`else
  localparam int unsigned TB_HOLD = 16;
  localparam bit          TB_TO   = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req, ip, gnt;
  logic [2:0] select;
  logic       y, busy, timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux8_rr_arbiter #(.N_REQ(8), .MAX_HOLD(TB_HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .ip      (ip),
    .gnt     (gnt),
    .select  (select),
    .y       (y),
    .busy    (busy),
    .timeout (timeout)
  );

  // Reference: owner index (-1 = nobody), priority pointer, cycles held so far.
  int m_owner, m_ptr, m_sel, m_cnt;
  bit m_y, m_to;

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_sel = 0; m_cnt = 0; m_y = 0; m_to = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic [7:0] d);
    m_to = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        int c;
        c = (m_ptr + k) % 8;
        if (r[c]) begin
          m_owner = c; m_sel = c; m_cnt = 1;
          break;
        end
      end
    end else if (!r[m_owner]) begin
      m_ptr = (m_owner + 1) % 8; m_owner = -1; m_y = 0;
    end else if (TB_TO && m_cnt == int'(TB_HOLD)) begin
      m_ptr = (m_owner + 1) % 8; m_owner = -1; m_y = 0; m_to = 1;
    end else begin
      m_y = d[m_owner];
      m_cnt++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step(req, ip);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] eg, input logic [2:0] es,
                     input logic ey, input logic eb, input logic et);
    checks++;
    if (gnt !== eg || select !== es || y !== ey || busy !== eb || timeout !== et) begin
      errors++;
      $display("FAIL %s: got gnt=%h sel=%0d y=%b busy=%b timeout=%b, expected gnt=%h sel=%0d y=%b busy=%b timeout=%b",
               nm, gnt, select, y, busy, timeout, eg, es, ey, eb, et);
    end
  endtask

  task automatic chk_model(input string nm);
    chk(nm, (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00, 3'(m_sel), m_y, m_owner >= 0, m_to);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; ip = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [7:0] req, ip, gnt;
    logic [2:0] sel;
    logic       y, busy;
  } vec_t;
  vec_t tbl[18];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] hold;

    tbl[0]  = '{8'h08, 8'hAA, 8'h08, 3'd3, 1'b0, 1'b1};
    tbl[1]  = '{8'h08, 8'hAA, 8'h08, 3'd3, 1'b1, 1'b1};
    tbl[2]  = '{8'h00, 8'hAA, 8'h00, 3'd3, 1'b0, 1'b0};
    tbl[3]  = '{8'h24, 8'hFF, 8'h20, 3'd5, 1'b0, 1'b1};
    tbl[4]  = '{8'h24, 8'hFF, 8'h20, 3'd5, 1'b1, 1'b1};
    tbl[5]  = '{8'h04, 8'hFF, 8'h00, 3'd5, 1'b0, 1'b0};
    tbl[6]  = '{8'h04, 8'h04, 8'h04, 3'd2, 1'b0, 1'b1};
    tbl[7]  = '{8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1};
    tbl[8]  = '{8'h00, 8'h04, 8'h00, 3'd2, 1'b0, 1'b0};
    tbl[9]  = '{8'h80, 8'h80, 8'h80, 3'd7, 1'b0, 1'b1};
    tbl[10] = '{8'h00, 8'h80, 8'h00, 3'd7, 1'b0, 1'b0};
    tbl[11] = '{8'h81, 8'h01, 8'h01, 3'd0, 1'b0, 1'b1};
    tbl[12] = '{8'h00, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[13] = '{8'h04, 8'h04, 8'h04, 3'd2, 1'b0, 1'b1};
    tbl[14] = '{8'h14, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1};
    tbl[15] = '{8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1};
    tbl[16] = '{8'h00, 8'h04, 8'h00, 3'd2, 1'b0, 1'b0};
    tbl[17] = '{8'h00, 8'h04, 8'h00, 3'd2, 1'b0, 1'b0};

    // Directed table: single requester, wrap/priority, ignored contention.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      req = tbl[i].req;
      ip  = tbl[i].ip;
      cyc();
      chk($sformatf("table[%0d]", i), tbl[i].gnt, tbl[i].sel, tbl[i].y, tbl[i].busy, 1'b0);
    end

    // Full load: every owner holds 3 cycles, one dead cycle between grants.
    do_reset();
    for (int e = 0; e < 9; e++) begin
      req = 8'hFF;
      for (int c = 0; c < 3; c++) begin
        cyc();
        chk($sformatf("full_grant%0d", e), 8'(1 << (e % 8)), 3'(e % 8), 1'b0, 1'b1, 1'b0);
      end
      req = 8'hFF & ~8'(1 << (e % 8));
      cyc();
      chk($sformatf("full_dead%0d", e), 8'h00, 3'(e % 8), 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-grant, then pointer back at 0.
    do_reset();
    req = 8'h10; cyc(); chk("mid_g1", 8'h10, 3'd4, 1'b0, 1'b1, 1'b0);
    req = 8'h00; cyc(); chk("mid_rel", 8'h00, 3'd4, 1'b0, 1'b0, 1'b0);
    req = 8'h10; ip = 8'h10;
    cyc(); chk("mid_g2", 8'h10, 3'd4, 1'b0, 1'b1, 1'b0);
    cyc(); chk("mid_y", 8'h10, 3'd4, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; req = 8'h30; ip = 8'h00;
    cyc(); chk("post_rst_ptr0", 8'h10, 3'd4, 1'b0, 1'b1, 1'b0);

    // Hold limit.
    do_reset();
    req = 8'h42;
    cyc(); chk("hold_start", 8'h02, 3'd1, 1'b0, 1'b1, 1'b0);
`ifdef MUX8_ARB_TIMEOUT_EN
    for (int c = 0; c < 3; c++) begin
      cyc(); chk("hold_keep", 8'h02, 3'd1, 1'b0, 1'b1, 1'b0);
    end
    cyc(); chk("timeout_pulse", 8'h00, 3'd1, 1'b0, 1'b0, 1'b1);
    cyc(); chk("after_timeout", 8'h40, 3'd6, 1'b0, 1'b1, 1'b0);
    cyc(); chk("pulse_once", 8'h40, 3'd6, 1'b0, 1'b1, 1'b0);
`else
    repeat (120) cyc();
    chk("no_timeout_120", 8'h02, 3'd1, 1'b0, 1'b1, 1'b0);
`endif

    // Random sticky requests against the reference model.
    do_reset();
    hold = 8'($urandom);
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 7) == 0) hold[b] = ~hold[b];
      req = ($urandom_range(0, 15) == 0) ? 8'($urandom) : hold;
      ip  = 8'($urandom);
      cyc();
      chk_model($sformatf("random[%0d]", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
